snake_tick_scheduler: RTL and testbench

Movement-rate controller for the snake game. It replaces free-running derived clocks with single-cycle `tick` enables on the system clock. Tick spacing is set by a speed level that rises as food is eaten. A game-state FSM (IDLE/RUN/PAUSE/OVER) sequences start, pause, game-over and restart. It sits between the game logic (food/collision events) and the snake movement and LCD update logic, which advance only on `tick`.

---
 rtl/snake_tick_scheduler.sv | 177 +++++++++++++++++
 tb/tb_snake_tick_scheduler.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/snake_tick_scheduler.sv
// Movement-rate controller: single-cycle tick enables, speed level from food count, IDLE/RUN/PAUSE/OVER FSM.
// Latency: tick is registered, high the cycle after the counter's terminal count; first tick BASE_PERIOD cycles after start.
// No backpressure: pulse inputs are sampled every cycle; optional blink phase under `SNAKE_TICK_BLINK_EN.
module snake_tick_scheduler #(
    parameter int BASE_PERIOD     = 35000000,
    parameter int STEP            = 4000000,
    parameter int MIN_PERIOD      = 5000000,
    parameter int FOODS_PER_LEVEL = 4,
    parameter int MAX_LEVEL       = 7,
    parameter int BLINK_PERIOD    = 12500000,
    parameter int CNT_W           = 27
) (
    input  logic       clk_ht,
    input  logic       rst,
    input  logic       start,
    input  logic       pause_req,
    input  logic       food,
    input  logic       collide,
    output logic       tick,
    output logic [2:0] level,
    output logic [1:0] state,
    output logic       blink
);

    localparam int FC_W = (FOODS_PER_LEVEL > 1) ? $clog2(FOODS_PER_LEVEL) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_OVER  = 2'b11
    } state_t;

    // Elaboration-time sanity check of the configuration.
    if (FOODS_PER_LEVEL < 1 || MAX_LEVEL > 7 || MAX_LEVEL < 0 || BLINK_PERIOD < 1 ||
        MIN_PERIOD < 1 || BASE_PERIOD < MIN_PERIOD || BASE_PERIOD >= (2 ** CNT_W)) begin : g_param_check
        $error("snake_tick_scheduler: illegal parameter combination");
    end

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] per_q, per_d;
    logic [2:0]       lvl_q, lvl_d;
    logic [FC_W-1:0]  fc_q, fc_d;
    logic             tick_q, tick_d;
    logic             terminal;

    // Tick spacing for a level: BASE - L*STEP, clamped to MIN without ever going below zero.
    function automatic logic [CNT_W-1:0] period_of(input logic [2:0] lvl);
        logic [31:0] red;
        red = 32'(lvl) * 32'(STEP);
        if (red >= 32'(BASE_PERIOD - MIN_PERIOD))
            period_of = CNT_W'(MIN_PERIOD);
        else
            period_of = CNT_W'(32'(BASE_PERIOD) - red);
    endfunction

    assign terminal = (cnt_q == per_q - CNT_W'(1));

    // Next-state logic: game FSM, movement counter, period reload and level progression.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        per_d   = per_q;
        lvl_d   = lvl_q;
        fc_d    = fc_q;
        tick_d  = 1'b0;
        case (state_q)
            ST_IDLE, ST_OVER: begin
                // start wins over a simultaneous pause_req; everything else is ignored
                if (start) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                    lvl_d   = '0;
                    fc_d    = '0;
                    per_d   = CNT_W'(BASE_PERIOD);
                end
            end
            ST_RUN: begin
                if (collide) begin
                    // counter held, pending tick dropped
                    state_d = ST_OVER;
                end else if (pause_req) begin
                    // counter held, a pending terminal count fires after resume
                    state_d = ST_PAUSE;
                end else begin
                    if (terminal) begin
                        cnt_d  = '0;
                        tick_d = 1'b1;
                        per_d  = period_of(lvl_q);
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    if (food) begin
                        if (fc_q == FC_W'(FOODS_PER_LEVEL - 1)) begin
                            fc_d = '0;
                            if (lvl_q < 3'(MAX_LEVEL))
                                lvl_d = lvl_q + 3'd1;
                        end else begin
                            fc_d = fc_q + FC_W'(1);
                        end
                    end
                end
            end
            ST_PAUSE: begin
                if (pause_req)
                    state_d = ST_RUN;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_ht) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            per_q   <= CNT_W'(BASE_PERIOD);
            lvl_q   <= '0;
            fc_q    <= '0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            per_q   <= per_d;
            lvl_q   <= lvl_d;
            fc_q    <= fc_d;
            tick_q  <= tick_d;
        end
    end

    assign tick  = tick_q;
    assign level = lvl_q;
    assign state = state_q;

`ifdef SNAKE_TICK_BLINK_EN
    localparam int BC_W = (BLINK_PERIOD > 1) ? $clog2(BLINK_PERIOD) : 1;

    logic [BC_W-1:0] bcnt_q, bcnt_d;
    logic            blink_q, blink_d;
    logic            blink_stay;

    // Blink runs only while remaining in PAUSE/OVER; entry or exit restarts the phase at 0.
    assign blink_stay = (state_q == ST_PAUSE || state_q == ST_OVER) && (state_d == state_q);

    // Blink divider: toggle every BLINK_PERIOD cycles spent in the state.
    always_comb begin
        bcnt_d  = '0;
        blink_d = 1'b0;
        if (blink_stay) begin
            if (bcnt_q == BC_W'(BLINK_PERIOD - 1)) begin
                bcnt_d  = '0;
                blink_d = ~blink_q;
            end else begin
                bcnt_d  = bcnt_q + BC_W'(1);
                blink_d = blink_q;
            end
        end
    end

    // Blink registers with synchronous reset.
    always_ff @(posedge clk_ht) begin
        if (rst) begin
            bcnt_q  <= '0;
            blink_q <= 1'b0;
        end else begin
            bcnt_q  <= bcnt_d;
            blink_q <= blink_d;
        end
    end

    assign blink = blink_q;
`else
    assign blink = 1'b0;
`endif

endmodule

// File: tb/tb_snake_tick_scheduler.sv
// Bench for snake_tick_scheduler: directed vector table plus randomized run against a reference model.
// Latency: outputs compared 1 time unit after every rising clk_ht edge.
// No backpressure: one stimulus record per clock cycle.
module tb_snake_tick_scheduler;

    localparam int BASE   = 10;
    localparam int STEP   = 2;
    localparam int MINP   = 4;
    localparam int FPL    = 2;
    localparam int MAXL   = 7;
    localparam int BLINKP = 3;

    logic       clk_ht = 1'b0;
    logic       rst = 1'b1, start = 1'b0, pause_req = 1'b0, food = 1'b0, collide = 1'b0;
    logic       tick;
    logic [2:0] level;
    logic [1:0] state;
    logic       blink;

    int tests = 0;
    int fails = 0;

    always #5 clk_ht = ~clk_ht;

    snake_tick_scheduler #(
        .BASE_PERIOD    (BASE),
        .STEP           (STEP),
        .MIN_PERIOD     (MINP),
        .FOODS_PER_LEVEL(FPL),
        .MAX_LEVEL      (MAXL),
        .BLINK_PERIOD   (BLINKP),
        .CNT_W          (8)
    ) dut (
        .clk_ht   (clk_ht),
        .rst      (rst),
        .start    (start),
        .pause_req(pause_req),
        .food     (food),
        .collide  (collide),
        .tick     (tick),
        .level    (level),
        .state    (state),
        .blink    (blink)
    );

    // Reference model: state 0..3, foods eaten since start, RUN cycles left until the next tick,
    // cycles spent in the current PAUSE/OVER stay.
    int m_st = 0, m_total = 0, m_rem = BASE, m_bc = 0;
    bit m_tick = 0;

    function automatic int m_period(int l);
        int p;
        p = BASE - l * STEP;
        return (p < MINP) ? MINP : p;
    endfunction

    function automatic int m_level();
        int l;
        l = m_total / FPL;
        return (l > MAXL) ? MAXL : l;
    endfunction

    function automatic bit m_blink();
`ifdef SNAKE_TICK_BLINK_EN
        return ((m_bc / BLINKP) % 2) == 1;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_step(input bit r, input bit s, input bit p, input bit f, input bit c);
        int prev;
        int lv;
        prev   = m_st;
        lv     = m_level();
        m_tick = 1'b0;
        if (r) begin
            m_st = 0; m_total = 0; m_rem = BASE;
        end else begin
            case (m_st)
                0, 3: if (s) begin m_st = 1; m_total = 0; m_rem = BASE; end
                1: begin
                    if (c) m_st = 3;
                    else if (p) m_st = 2;
                    else begin
                        m_rem = m_rem - 1;
                        if (m_rem == 0) begin
                            m_tick = 1'b1;
                            m_rem  = m_period(lv);
                        end
                        if (f) m_total = m_total + 1;
                    end
                end
                default: if (p) m_st = 1;
            endcase
        end
        if (!r && m_st == prev && (m_st == 2 || m_st == 3)) m_bc = m_bc + 1;
        else m_bc = 0;
    endtask

    // One clock: drive inputs, advance model, compare all outputs after the edge.
    task automatic cyc(input bit r, input bit s, input bit p, input bit f, input bit c);
        rst = r; start = s; pause_req = p; food = f; collide = c;
        model_step(r, s, p, f, c);
        @(posedge clk_ht);
        #1;
        tests++;
        if (tick !== m_tick || level !== 3'(m_level()) || state !== 2'(m_st) || blink !== m_blink()) begin
            fails++;
            $display("FAIL model t=%0t: got tick=%b level=%0d state=%0d blink=%b, want tick=%b level=%0d state=%0d blink=%b",
                     $time, tick, level, state, blink, m_tick, m_level(), m_st, m_blink());
        end
    endtask

    task automatic chk(input string n, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d", n, act, exp);
        end
    endtask

    typedef struct {
        string name;
        bit    r, s, p, f, c;
        int    idle;
        bit    etick;
        int    elevel;
        int    estate;
    } vec_t;

    vec_t vq[$];

    // Record: inputs for one cycle, then 'idle' quiet cycles, then expected outputs.
    function automatic void add(input string n, input bit r, input bit s, input bit p, input bit f,
                                input bit c, input int idle, input bit et, input int el, input int es);
        vec_t v;
        v.name = n; v.r = r; v.s = s; v.p = p; v.f = f; v.c = c;
        v.idle = idle; v.etick = et; v.elevel = el; v.estate = es;
        vq.push_back(v);
    endfunction

    initial begin
        // 1: basic tick spacing
        add("t1_rst",      1, 0, 0, 0, 0, 0, 0, 0, 0);
        add("t1_pre10",    0, 1, 0, 0, 0, 9, 0, 0, 1);
        add("t1_tick10",   0, 0, 0, 0, 0, 0, 1, 0, 1);
        add("t1_post10",   0, 0, 0, 0, 0, 0, 0, 0, 1);
        add("t1_pre20",    0, 0, 0, 0, 0, 7, 0, 0, 1);
        add("t1_tick20",   0, 0, 0, 0, 0, 0, 1, 0, 1);
        add("t1_pre30",    0, 0, 0, 0, 0, 8, 0, 0, 1);
        add("t1_tick30",   0, 0, 0, 0, 0, 0, 1, 0, 1);
        // 2: level 1 shortens the next gap to 8
        add("t2_rst",      1, 0, 0, 0, 0, 0, 0, 0, 0);
        add("t2_start",    0, 1, 0, 0, 0, 1, 0, 0, 1);
        add("t2_food1",    0, 0, 0, 1, 0, 0, 0, 0, 1);
        add("t2_gap",      0, 0, 0, 0, 0, 0, 0, 0, 1);
        add("t2_food2",    0, 0, 0, 1, 0, 0, 0, 1, 1);
        add("t2_pre10",    0, 0, 0, 0, 0, 4, 0, 1, 1);
        add("t2_tick10",   0, 0, 0, 0, 0, 0, 1, 1, 1);
        add("t2_pre18",    0, 0, 0, 0, 0, 6, 0, 1, 1);
        add("t2_tick18",   0, 0, 0, 0, 0, 0, 1, 1, 1);
        // 3: level saturates at 7, period clamps at 4 (reload at cycle 10 already sees level 4)
        add("t3_rst",      1, 0, 0, 0, 0, 0, 0, 0, 0);
        add("t3_start",    0, 1, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 1; i <= 18; i++)
            add($sformatf("t3_food%0d", i), 0, 0, 0, 1, 0, 0,
                (i == 10 || i == 14 || i == 18), ((i / 2) > 7) ? 7 : (i / 2), 1);
        add("t3_pre22",    0, 0, 0, 0, 0, 2, 0, 7, 1);
        add("t3_tick22",   0, 0, 0, 0, 0, 0, 1, 7, 1);
        // 4: pause at counter 5 for 20 cycles; 10 RUN cycles between ticks
        add("t4_rst",      1, 0, 0, 0, 0, 0, 0, 0, 0);
        add("t4_pre10",    0, 1, 0, 0, 0, 9, 0, 0, 1);
        add("t4_tick10",   0, 0, 0, 0, 0, 0, 1, 0, 1);
        add("t4_cnt5",     0, 0, 0, 0, 0, 4, 0, 0, 1);
        add("t4_pause",    0, 0, 1, 0, 0, 0, 0, 0, 2);
        add("t4_paused",   0, 0, 0, 1, 1, 18, 0, 0, 2);
        add("t4_resume",   0, 0, 1, 0, 0, 0, 0, 0, 1);
        add("t4_pre41",    0, 0, 0, 0, 0, 3, 0, 0, 1);
        add("t4_tick41",   0, 0, 0, 0, 0, 0, 1, 0, 1);
        // 5: collide on terminal count, food ignored in OVER, restart
        add("t5_rst",      1, 0, 0, 0, 0, 0, 0, 0, 0);
        add("t5_pre10",    0, 1, 0, 0, 0, 9, 0, 0, 1);
        add("t5_collide",  0, 0, 0, 0, 1, 0, 0, 0, 3);
        add("t5_food_a",   0, 0, 1, 1, 0, 0, 0, 0, 3);
        add("t5_food_b",   0, 0, 0, 1, 0, 0, 0, 0, 3);
        add("t5_restart",  0, 1, 1, 0, 0, 9, 0, 0, 1);
        add("t5_tick",     0, 0, 0, 0, 0, 0, 1, 0, 1);
        // 6: reset mid-RUN at level 3
        add("t6_rst",      1, 0, 0, 0, 0, 0, 0, 0, 0);
        add("t6_start",    0, 1, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 1; i <= 6; i++)
            add($sformatf("t6_food%0d", i), 0, 0, 0, 1, 0, 0, 0, i / 2, 1);
        add("t6_midrst",   1, 1, 1, 1, 0, 0, 0, 0, 0);
        add("t6_idle",     0, 0, 1, 1, 1, 15, 0, 0, 0);

        foreach (vq[k]) begin
            cyc(vq[k].r, vq[k].s, vq[k].p, vq[k].f, vq[k].c);
            repeat (vq[k].idle) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            chk({vq[k].name, "_tick"},  int'(tick),  int'(vq[k].etick));
            chk({vq[k].name, "_level"}, int'(level), vq[k].elevel);
            chk({vq[k].name, "_state"}, int'(state), vq[k].estate);
            chk({vq[k].name, "_blink_rst"}, int'(blink && vq[k].r), 0);
        end

        // Randomized run: long pauses/overs exercise blink, many foods exercise saturation.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4000; i++) begin
            cyc($urandom_range(0, 299) == 0,
                $urandom_range(0, 39) == 0,
                $urandom_range(0, 29) == 0,
                $urandom_range(0, 5) == 0,
                $urandom_range(0, 199) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
